pswd_enroll_ctrl: RTL and testbench
===================================

// Module: pswd_enroll_ctrl
// PURPOSE
//  Write-side companion to the password lookup path: lets an already-authorised user replace
//  the stored password for the current internal ID. Collects a new password digit-by-digit from
//  toggles, requires identical re-entry, then writes it to the password RAM via req/ack handshake.
//  Sits beside the password check block; consumes its authorise_bit and internalid.
// PARAMETERS
//  ID_W        4      width of internal user ID / RAM address
//  DIGIT_W     4      width of one password digit (toggle bank)
//  NUM_DIGITS  4      digits per password; wr_data width = NUM_DIGITS*DIGIT_W
//  TIMEOUT_CYC 1024   idle cycles in ENTER/CONFIRM before abort (>=2)
// PORTS
//  clk            in   1        system clock, rising edge
//  reset          in   1        asynchronous, active-low reset
//  authorise_bit  in   1        1 = current user authenticated
//  internalid     in   ID_W     ID of authenticated user
//  in_toggle_pswd in   DIGIT_W  digit value on toggles
//  digit_btn      in   1        one-cycle pulse (button-shaped): capture digit
//  change_btn     in   1        one-cycle pulse: start enrollment
//  logout         in   1        one-cycle pulse: abort, return to IDLE
//  wr_req         out  1        RAM write request, held until wr_ack
//  wr_ack         in   1        RAM accepted write (1 cycle)
//  wr_addr        out  ID_W     write address (latched internalid)
//  wr_data        out  NUM_DIGITS*DIGIT_W  new password, digit 0 in MSBs
//  busy           out  1        1 in any state except IDLE
//  done_led       out  1        1 in DONE
//  err_led        out  1        1 in FAIL
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; wr_req, busy, done_led, err_led = 0; wr_addr, wr_data,
//   digit counter, timeout counter, shadow register = 0. All outputs registered.
//  States: IDLE, ENTER, CONFIRM, WRITE, DONE, FAIL.
//  IDLE: change_btn & authorise_bit -> ENTER; latch internalid into wr_addr; clear counters.
//   change_btn without authorise_bit -> FAIL.
//  ENTER: each digit_btn shifts in_toggle_pswd into wr_data at slot digit_cnt; after digit
//   NUM_DIGITS-1 captured -> CONFIRM, digit_cnt wraps to 0.
//  CONFIRM: each digit_btn compares in_toggle_pswd with stored slot; any mismatch sets sticky
//   flag. After last digit: flag clear -> WRITE, else -> FAIL.
//  WRITE: wr_req=1 from first WRITE cycle, wr_addr/wr_data stable while wr_req=1; wr_ack -> DONE,
//   wr_req drops the same edge. wr_ack outside WRITE is ignored.
//  DONE / FAIL: LED held 1; next change_btn or logout -> IDLE (change_btn not re-armed same cycle).
//  Timeout: counter clears on every digit_btn and on state entry; reaching TIMEOUT_CYC-1 in
//   ENTER/CONFIRM -> FAIL. No timeout in WRITE (RAM must ack).
//  authorise_bit falling in ENTER/CONFIRM -> FAIL. In WRITE it is ignored (write completes).
//  logout: ENTER/CONFIRM -> IDLE (no write); in WRITE ignored until wr_ack, then DONE.
//  Priority same cycle: logout > authorise_bit loss > timeout > digit_btn.
//  digit_btn and change_btn together in ENTER: digit_btn taken, change_btn ignored.
//  Reset mid-WRITE: wr_req drops immediately; partial RAM state is the RAM's concern.
// STRUCTURE
//  Shared package/header: state encoding constants (3-bit), ID_W, DIGIT_W, NUM_DIGITS defaults
//   so password check and enrollment agree on layout.
//  One sub-module natural: enroll_timeout_cnt (loadable clear, terminal-count pulse).
//  FSM, digit counter, shadow/compare logic stay in this module.
// TESTING (NUM_DIGITS=4, DIGIT_W=4, TIMEOUT_CYC=16)
//  1 auth=1,id=5; change; digits 3,7,1,9; confirm 3,7,1,9; ack after 3 cycles -> wr_req 3 cycles,
//    wr_addr=5, wr_data=16'h3719, done_led=1.
//  2 Same entry, confirm 3,7,2,9 -> err_led=1 after 4th confirm digit, wr_req never asserted.
//  3 auth=0, change -> FAIL next cycle; logout -> IDLE, all outputs 0.
//  4 ENTER, 2 digits, then 16 cycles no press -> FAIL; press at cycle 15 instead -> still ENTER.
//  5 logout during CONFIRM -> IDLE, no wr_req; logout during WRITE -> held until ack, then DONE.
//  6 reset low while wr_req=1 -> wr_req=0 asynchronously, state IDLE, wr_data=0.

Source files
------------

// File: rtl/pswd_enroll_ctrl_pkg.sv
// Shared layout and state encoding for the password check and enrollment paths.
package pswd_enroll_ctrl_pkg;

    localparam int unsigned ENR_ID_W        = 4;
    localparam int unsigned ENR_DIGIT_W     = 4;
    localparam int unsigned ENR_NUM_DIGITS  = 4;
    localparam int unsigned ENR_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER   = 3'd1,
        S_CONFIRM = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4,
        S_FAIL    = 3'd5
    } enroll_state_e;

endpackage

// File: rtl/enroll_timeout_cnt.sv
// Idle-cycle counter with synchronous clear; saturates and flags terminal count.
module enroll_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != TERMINAL) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = (cnt == TERMINAL);

endmodule

// File: rtl/pswd_enroll_ctrl.sv
// Password enrollment: collect, confirm and write a new password for the logged-in ID.
module pswd_enroll_ctrl
    import pswd_enroll_ctrl_pkg::*;
#(
    parameter int unsigned ID_W        = ENR_ID_W,
    parameter int unsigned DIGIT_W     = ENR_DIGIT_W,
    parameter int unsigned NUM_DIGITS  = ENR_NUM_DIGITS,
    parameter int unsigned TIMEOUT_CYC = ENR_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          authorise_bit,
    input  logic [ID_W-1:0]               internalid,
    input  logic [DIGIT_W-1:0]            in_toggle_pswd,
    input  logic                          digit_btn,
    input  logic                          change_btn,
    input  logic                          logout,
    output logic                          wr_req,
    input  logic                          wr_ack,
    output logic [ID_W-1:0]               wr_addr,
    output logic [NUM_DIGITS*DIGIT_W-1:0] wr_data,
    output logic                          busy,
    output logic                          done_led,
    output logic                          err_led
);

    localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    enroll_state_e                        state;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   pswd;
    logic [CNT_W-1:0]                     digit_cnt;
    logic                                 mismatch;
    logic [CNT_W-1:0]                     slot_c;
    logic                                 last_c;
    logic                                 digit_match_c;
    logic                                 timeout_clear_c;
    logic                                 timeout_c;

    // Digit 0 lands in the most significant slot.
    assign slot_c        = LAST_DIGIT - digit_cnt;
    assign last_c        = (digit_cnt == LAST_DIGIT);
    assign digit_match_c = (pswd[slot_c] == in_toggle_pswd);
    assign wr_data       = pswd;

    // Counter only runs while waiting for digits; held clear everywhere else.
    assign timeout_clear_c = digit_btn | ~((state == S_ENTER) | (state == S_CONFIRM));

    enroll_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (timeout_clear_c),
        .expired_c (timeout_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wr_req    <= 1'b0;
            busy      <= 1'b0;
            done_led  <= 1'b0;
            err_led   <= 1'b0;
            wr_addr   <= '0;
            pswd      <= '0;
            digit_cnt <= '0;
            mismatch  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (change_btn) begin
                        busy <= 1'b1;
                        if (authorise_bit) begin
                            state     <= S_ENTER;
                            wr_addr   <= internalid;
                            digit_cnt <= '0;
                            mismatch  <= 1'b0;
                        end else begin
                            state   <= S_FAIL;
                            err_led <= 1'b1;
                        end
                    end
                end

                // Priority: logout > authorisation loss > timeout > digit.
                S_ENTER, S_CONFIRM: begin
                    if (logout) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        wr_addr <= '0;
                        pswd    <= '0;
                    end else if (!authorise_bit || timeout_c) begin
                        state   <= S_FAIL;
                        err_led <= 1'b1;
                    end else if (digit_btn) begin
                        digit_cnt <= last_c ? '0 : digit_cnt + CNT_W'(1);
                        if (state == S_ENTER) begin
                            pswd[slot_c] <= in_toggle_pswd;
                            if (last_c) begin
                                state <= S_CONFIRM;
                            end
                        end else begin
                            mismatch <= mismatch | ~digit_match_c;
                            if (last_c) begin
                                if (mismatch || !digit_match_c) begin
                                    state   <= S_FAIL;
                                    err_led <= 1'b1;
                                end else begin
                                    state  <= S_WRITE;
                                    wr_req <= 1'b1;
                                end
                            end
                        end
                    end
                end

                // Write always completes; logout and auth loss wait for the ack.
                S_WRITE: begin
                    if (wr_ack) begin
                        state    <= S_DONE;
                        wr_req   <= 1'b0;
                        done_led <= 1'b1;
                    end
                end

                S_DONE, S_FAIL: begin
                    if (change_btn || logout) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        done_led <= 1'b0;
                        err_led  <= 1'b0;
                        wr_addr  <= '0;
                        pswd     <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pswd_enroll_ctrl.sv
// Directed bench for pswd_enroll_ctrl with hand-computed expectations.
module tb_pswd_enroll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        authorise_bit;
    logic [3:0]  internalid;
    logic [3:0]  in_toggle_pswd;
    logic        digit_btn;
    logic        change_btn;
    logic        logout;
    logic        wr_req;
    logic        wr_ack;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done_led;
    logic        err_led;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cycles = 0;
    int base;

    pswd_enroll_ctrl #(
        .ID_W        (4),
        .DIGIT_W     (4),
        .NUM_DIGITS  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .authorise_bit  (authorise_bit),
        .internalid     (internalid),
        .in_toggle_pswd (in_toggle_pswd),
        .digit_btn      (digit_btn),
        .change_btn     (change_btn),
        .logout         (logout),
        .wr_req         (wr_req),
        .wr_ack         (wr_ack),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .done_led       (done_led),
        .err_led        (err_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_req === 1'b1) req_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_change();
        change_btn = 1'b1;
        tick();
        change_btn = 1'b0;
    endtask

    task automatic pulse_logout();
        logout = 1'b1;
        tick();
        logout = 1'b0;
    endtask

    task automatic pulse_digit(input logic [3:0] d);
        in_toggle_pswd = d;
        digit_btn = 1'b1;
        tick();
        digit_btn = 1'b0;
    endtask

    task automatic send_pw(input logic [15:0] pw);
        for (int i = 0; i < 4; i++) begin
            pulse_digit(pw[15-4*i -: 4]);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"},    32'(busy),     32'd0);
        check({tag, ".wr_req"},  32'(wr_req),   32'd0);
        check({tag, ".done"},    32'(done_led), 32'd0);
        check({tag, ".err"},     32'(err_led),  32'd0);
        check({tag, ".wr_addr"}, 32'(wr_addr),  32'd0);
        check({tag, ".wr_data"}, 32'(wr_data),  32'd0);
    endtask

    initial begin
        reset = 1'b0;
        authorise_bit = 1'b0;
        internalid = 4'd0;
        in_toggle_pswd = 4'd0;
        digit_btn = 1'b0;
        change_btn = 1'b0;
        logout = 1'b0;
        wr_ack = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b1;
        tick();

        // 1: full enrollment, ack after three request cycles
        authorise_bit = 1'b1;
        internalid = 4'd5;
        pulse_change();
        check("t1.busy", 32'(busy), 32'd1);
        check("t1.addr", 32'(wr_addr), 32'd5);
        send_pw(16'h3719);
        check("t1.data_enter", 32'(wr_data), 32'h3719);
        check("t1.no_req_enter", 32'(wr_req), 32'd0);
        base = req_cycles;
        send_pw(16'h3719);
        check("t1.req_on", 32'(wr_req), 32'd1);
        tick();
        check("t1.req_hold", 32'(wr_req), 32'd1);
        check("t1.data_hold", 32'(wr_data), 32'h3719);
        tick();
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("t1.req_drop", 32'(wr_req), 32'd0);
        check("t1.done", 32'(done_led), 32'd1);
        check("t1.req_cycles", 32'(req_cycles - base), 32'd3);
        check("t1.addr_done", 32'(wr_addr), 32'd5);
        tick();
        check("t1.done_held", 32'(done_led), 32'd1);
        pulse_change();
        check_idle("t1.exit");
        tick();
        check("t1.not_rearmed", 32'(busy), 32'd0);

        // 2: confirm mismatch on third digit
        base = req_cycles;
        pulse_change();
        send_pw(16'h3719);
        pulse_digit(4'h3);
        pulse_digit(4'h7);
        pulse_digit(4'h2);
        check("t2.err_early", 32'(err_led), 32'd0);
        pulse_digit(4'h9);
        check("t2.err", 32'(err_led), 32'd1);
        check("t2.busy", 32'(busy), 32'd1);
        tick();
        check("t2.no_req", 32'(req_cycles - base), 32'd0);
        pulse_logout();
        check_idle("t2.exit");

        // 3: change without authorisation
        authorise_bit = 1'b0;
        pulse_change();
        check("t3.err", 32'(err_led), 32'd1);
        check("t3.busy", 32'(busy), 32'd1);
        pulse_logout();
        check_idle("t3.exit");
        authorise_bit = 1'b1;

        // wr_ack outside WRITE has no effect
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("ack_idle.done", 32'(done_led), 32'd0);

        // 4a: timeout after 16 idle cycles in ENTER
        pulse_change();
        pulse_digit(4'h1);
        pulse_digit(4'h2);
        for (int i = 0; i < 15; i++) tick();
        check("t4.no_timeout_15", 32'(err_led), 32'd0);
        tick();
        check("t4.timeout_16", 32'(err_led), 32'd1);
        pulse_logout();

        // 4b: press during the 15th idle cycle keeps ENTER alive
        pulse_change();
        pulse_digit(4'h1);
        pulse_digit(4'h2);
        for (int i = 0; i < 14; i++) tick();
        pulse_digit(4'h3);
        check("t4.press15_err", 32'(err_led), 32'd0);
        check("t4.press15_data", 32'(wr_data), 32'h1230);
        pulse_logout();
        check_idle("t4.exit");

        // authorisation loss in ENTER fails; logout wins over it
        pulse_change();
        pulse_digit(4'h4);
        authorise_bit = 1'b0;
        tick();
        check("auth_loss.err", 32'(err_led), 32'd1);
        pulse_logout();
        authorise_bit = 1'b1;
        pulse_change();
        pulse_digit(4'h4);
        authorise_bit = 1'b0;
        pulse_logout();
        check("prio.busy", 32'(busy), 32'd0);
        check("prio.err", 32'(err_led), 32'd0);
        authorise_bit = 1'b1;

        // 5a: logout during CONFIRM
        base = req_cycles;
        pulse_change();
        send_pw(16'h1234);
        pulse_digit(4'h1);
        pulse_digit(4'h2);
        pulse_logout();
        check_idle("t5.confirm_logout");
        tick();
        check("t5.no_req", 32'(req_cycles - base), 32'd0);

        // 5b: logout and auth loss during WRITE wait for ack
        internalid = 4'd12;
        pulse_change();
        send_pw(16'h4321);
        send_pw(16'h4321);
        check("t5.req_on", 32'(wr_req), 32'd1);
        authorise_bit = 1'b0;
        pulse_logout();
        check("t5.req_held", 32'(wr_req), 32'd1);
        check("t5.busy_held", 32'(busy), 32'd1);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("t5.done", 32'(done_led), 32'd1);
        check("t5.data", 32'(wr_data), 32'h4321);
        check("t5.addr", 32'(wr_addr), 32'd12);
        authorise_bit = 1'b1;
        pulse_logout();
        check_idle("t5.exit");

        // 6: asynchronous reset while requesting
        internalid = 4'd9;
        pulse_change();
        send_pw(16'h5a5a);
        send_pw(16'h5a5a);
        check("t6.req_on", 32'(wr_req), 32'd1);
        check("t6.addr", 32'(wr_addr), 32'd9);
        #2;
        reset = 1'b0;
        #1;
        check_idle("t6.async");
        tick();
        reset = 1'b1;
        tick();
        check("t6.after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
